// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions.
// FSM state type and default operand width.
package arith_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_datapath.sv
// Restoring divider datapath: R/Q/D registers,
// trial subtractor and registered result.
module seq_restoring_divider_datapath
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             accept_i,
  input  logic             write_result_i,
  input  logic             write_dbz_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             trial_neg_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o
);

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  // Shift {R,Q} left, subtract D, keep or restore.
  always_comb begin
    shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = shifted - {1'b0, d_q};
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    if (load_i) begin
      r_d = '0;
      q_d = dividend_i;
      d_d = divisor_i;
    end else if (step_i) begin
      r_d = accept_i ? trial : shifted;
      q_d = {q_q[WIDTH-2:0], accept_i};
    end
  end

  assign trial_neg_o = trial[WIDTH];

  // Working registers; result uses this edge's step.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      if (write_result_i) begin
        quot_q <= q_d;
        rem_q  <= r_d[WIDTH-1:0];
        dbz_q  <= 1'b0;
      end else if (write_dbz_i) begin
        quot_q <= '1;
        rem_q  <= dividend_i;
        dbz_q  <= 1'b1;
      end
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign dbz_o       = dbz_q;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient
// bit per clock behind a start/done handshake.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t    state_q;
  logic [CW-1:0] count_q;
  logic          busy_q;
  logic          done_q;

  logic load;
  logic step;
  logic accept;
  logic write_result;
  logic write_dbz;
  logic trial_neg;
  logic div_zero;

  // Control decode from state and status.
  always_comb begin
    div_zero     = (divisor == '0);
    load         = (state_q == IDLE) && start && !div_zero;
    write_dbz    = (state_q == IDLE) && start && div_zero;
    step         = (state_q == CALC);
    accept       = step && !trial_neg;
    write_result = step && (count_q == LAST);
  end

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (!div_zero) begin
              state_q <= CALC;
              count_q <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  seq_restoring_divider_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk           (clk),
    .clr           (clr),
    .load_i        (load),
    .step_i        (step),
    .accept_i      (accept),
    .write_result_i(write_result),
    .write_dbz_i   (write_dbz),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .trial_neg_o   (trial_neg),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .dbz_o         (div_by_zero)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
